// File: rtl/spi_slave_ram_burst.sv
// SPI slave with an embedded single-port RAM, clocked directly by SCK.
// Supports burst reads/writes with address auto-increment and frame-abort detection.
module spi_slave_ram_burst #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic SCK,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned SrWa  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned SrW   = (SrWa < 2) ? 2 : SrWa;
  localparam int unsigned CntW  = $clog2(SrW + 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StWrAddr, StWrData, StRdAddr, StRdData, StHold
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SrW-1:0]      rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [Depth];
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic [SrW-1:0]      rx_shift;
  logic [ADDR_W-1:0]   addr_inc;
  logic [CntW-1:0]     cnt_inc;

  assign rx_shift  = {rx_sr_q[SrW-2:0], MOSI};
  assign addr_inc  = addr_q + ADDR_W'(AUTO_INC);
  assign cnt_inc   = bit_cnt_q + CntW'(1);
  assign mem_rdata = mem[addr_q];
  assign mem_wdata = rx_shift[DATA_W-1:0];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!SS_n) begin
          state_d   = StCmd;
          err_d     = 1'b0;
          bit_cnt_d = '0;
        end
      end
      StCmd: begin
        if (SS_n) begin
          // Any deselect before the opcode completes is an abort.
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          rx_sr_d   = rx_shift;
          bit_cnt_d = cnt_inc;
          if (bit_cnt_q == CntW'(1)) begin
            bit_cnt_d = '0;
            case (rx_shift[1:0])
              2'b00: state_d = StWrAddr;
              2'b01: state_d = StWrData;
              2'b10: state_d = StRdAddr;
              default: begin
                state_d = StRdData;
                tx_sr_d = mem_rdata;
                addr_d  = addr_inc;
              end
            endcase
          end
        end
      end
      StWrAddr, StRdAddr: begin
        if (SS_n) begin
          state_d = StIdle;
          if (bit_cnt_q != '0) err_d = 1'b1;
        end else begin
          rx_sr_d   = rx_shift;
          bit_cnt_d = cnt_inc;
          if (bit_cnt_q == CntW'(ADDR_W - 1)) begin
            addr_d    = rx_shift[ADDR_W-1:0];
            bit_cnt_d = '0;
            state_d   = StHold;
          end
        end
      end
      StWrData: begin
        if (SS_n) begin
          state_d = StIdle;
          if (bit_cnt_q != '0) err_d = 1'b1;
        end else begin
          rx_sr_d   = rx_shift;
          bit_cnt_d = cnt_inc;
          if (bit_cnt_q == CntW'(DATA_W - 1)) begin
            mem_we    = 1'b1;
            addr_d    = addr_inc;
            bit_cnt_d = '0;
          end
        end
      end
      StRdData: begin
        if (SS_n) begin
          state_d = StIdle;
          if (bit_cnt_q != '0) err_d = 1'b1;
        end else begin
          tx_sr_d   = tx_sr_q << 1;
          bit_cnt_d = cnt_inc;
          if (bit_cnt_q == CntW'(DATA_W - 1)) begin
            // Prefetch the next word on the last bit so the burst has no gap.
            tx_sr_d   = mem_rdata;
            addr_d    = addr_inc;
            bit_cnt_d = '0;
          end
        end
      end
      StHold: begin
        if (SS_n) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SCK or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      bit_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
    end
  end

  // RAM is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge SCK) begin
    if (mem_we && !rst) mem[addr_q] <= mem_wdata;
  end

  assign MISO      = (state_q == StRdData) ? tx_sr_q[DATA_W-1] : 1'b0;
  assign busy      = (state_q != StIdle);
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_slave_ram_burst.sv
// Bench for spi_slave_ram_burst: frame-level model of RAM/address plus per-edge output checks.
// A second instance covers the 16-bit data, 4-bit address, no-increment configuration.
module tb_spi_slave_ram_burst;

  logic SCK, rst;
  logic SS_n, MOSI, MISO, busy, frame_err;
  logic SS_n2, MOSI2, MISO2, busy2, frame_err2;

  spi_slave_ram_burst #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(1)) dut (
    .SCK(SCK), .rst(rst), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .busy(busy), .frame_err(frame_err)
  );

  spi_slave_ram_burst #(.ADDR_W(4), .DATA_W(16), .AUTO_INC(0)) dut2 (
    .SCK(SCK), .rst(rst), .SS_n(SS_n2), .MOSI(MOSI2),
    .MISO(MISO2), .busy(busy2), .frame_err(frame_err2)
  );

  initial SCK = 1'b0;
  always #5 SCK = ~SCK;

  int n_cmp = 0;
  int n_err = 0;

  logic       chk_en = 1'b0;
  logic       sel = 1'b0;
  logic       exp_miso, exp_busy, exp_err;
  logic [7:0] mem_m [256];
  logic [7:0] addr_m;
  bit         pl [$];
  logic [63:0] cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge SCK) begin
    if (chk_en) begin
      check("miso", {31'd0, MISO}, {31'd0, exp_miso});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("frame_err", {31'd0, frame_err}, {31'd0, exp_err});
    end
  end

  // One SCK rising edge with given inputs, then the outputs expected after it.
  task automatic drive(input logic ss, input logic mosi, input logic em, input logic eb,
                       input logic ee);
    @(negedge SCK);
    if (!sel) begin SS_n = ss; MOSI = mosi; end
    else begin SS_n2 = ss; MOSI2 = mosi; end
    @(posedge SCK);
    #1;
    exp_miso = em;
    exp_busy = eb;
    exp_err  = ee;
    chk_en   = !sel;
  endtask

  task automatic push(input logic [31:0] v, input int w);
    for (int b = w - 1; b >= 0; b--) pl.push_back(v[b]);
  endtask

  // Full frame: start slot, nop opcode bits, payload from pl, then deselect.
  task automatic frame(input int nop, input logic [1:0] op);
    bit   stream [$];
    int   n, k;
    logic rd, part;
    logic [7:0] w;
    n  = pl.size();
    k  = n / 8;
    rd = (nop == 2) && (op == 2'b11);
    if (rd) begin
      for (int i = 0; i <= k; i++) begin
        w = mem_m[8'(addr_m + 8'(i))];
        for (int b = 7; b >= 0; b--) stream.push_back(w[b]);
      end
    end
    drive(1'b0, 1'($urandom), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < nop; i++) begin
      drive(1'b0, op[1-i], (rd && i == 1) ? stream[0] : 1'b0, 1'b1, 1'b0);
      if (rd && i == 1) cap = {cap[62:0], MISO};
    end
    for (int j = 1; j <= n; j++) begin
      drive(1'b0, rd ? 1'($urandom) : pl[j-1], rd ? stream[j] : 1'b0, 1'b1, 1'b0);
      if (rd) cap = {cap[62:0], MISO};
    end
    if (nop < 2) part = 1'b1;
    else if (op[0] == 1'b0) part = (n > 0) && (n < 8);
    else part = (n % 8) != 0;
    drive(1'b1, 1'($urandom), 1'b0, 1'b0, part);
    if (nop == 2) begin
      if (op[0] == 1'b0) begin
        if (n >= 8) for (int b = 0; b < 8; b++) addr_m[7-b] = pl[b];
      end else if (op[1] == 1'b0) begin
        for (int i = 0; i < k; i++) begin
          for (int b = 0; b < 8; b++) w[7-b] = pl[i*8+b];
          mem_m[addr_m] = w;
          addr_m = addr_m + 8'd1;
        end
      end else begin
        addr_m = addr_m + 8'(k + 1);
      end
    end
    check("addr", {24'd0, dut.addr_q}, {24'd0, addr_m});
    pl.delete();
  endtask

  task automatic set_addr(input logic [7:0] a);
    push(a, 8);
    frame(2, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; SS_n2 = 1'b1; MOSI2 = 1'b0;
    addr_m = 8'h00; cap = '0;
    exp_miso = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
    #12;
    check("rst_miso", {31'd0, MISO}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_addr", {24'd0, dut.addr_q}, 32'd0);
    @(negedge SCK);
    rst = 1'b0;

    // Address write
    set_addr(8'hA5);
    check("addr_a5", {24'd0, dut.addr_q}, 32'hA5);

    // Single write
    set_addr(8'h10);
    push(8'h3C, 8);
    frame(2, 2'b01);
    check("mem10", {24'd0, dut.mem[8'h10]}, 32'h3C);
    check("addr_11", {24'd0, dut.addr_q}, 32'h11);

    // Burst write with address wrap
    set_addr(8'hFE);
    push(8'h11, 8); push(8'h22, 8); push(8'h33, 8);
    frame(2, 2'b01);
    check("memfe", {24'd0, dut.mem[8'hFE]}, 32'h11);
    check("memff", {24'd0, dut.mem[8'hFF]}, 32'h22);
    check("mem00", {24'd0, dut.mem[8'h00]}, 32'h33);
    check("addr_01", {24'd0, dut.addr_q}, 32'h01);

    // Burst read, gap-free across the word boundary
    set_addr(8'h20);
    push(8'h5A, 8); push(8'hC3, 8); push(8'h96, 8);
    frame(2, 2'b01);
    push(8'h20, 8);
    frame(2, 2'b10);
    for (int i = 0; i < 16; i++) pl.push_back(1'b0);
    frame(2, 2'b11);
    check("rd_stream", {16'd0, cap[16:1]}, 32'h5AC3);
    check("addr_23", {24'd0, dut.addr_q}, 32'h23);

    // Abort mid-word: no write, no address change, sticky error
    set_addr(8'h40);
    push(8'h77, 8);
    frame(2, 2'b01);
    set_addr(8'h40);
    push(5'b10101, 5);
    frame(2, 2'b01);
    check("mem40", {24'd0, dut.mem[8'h40]}, 32'h77);
    check("addr_40", {24'd0, dut.addr_q}, 32'h40);
    check("err_set", {31'd0, frame_err}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Truncated opcode also aborts
    frame(1, 2'b01);
    check("err_cmd", {31'd0, frame_err}, 32'd1);

    // Async reset in the middle of a read burst (start edge also clears the error)
    set_addr(8'h20);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_miso", {31'd0, MISO}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_err", {31'd0, frame_err}, 32'd0);
    check("arst_addr", {24'd0, dut.addr_q}, 32'd0);
    check("arst_mem20", {24'd0, dut.mem[8'h20]}, 32'h5A);
    check("arst_mem21", {24'd0, dut.mem[8'h21]}, 32'hC3);
    SS_n = 1'b1;
    @(negedge SCK);
    rst = 1'b0;
    addr_m = 8'h00;
    exp_miso = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
    set_addr(8'h21);
    push(8'h00, 8);
    frame(2, 2'b11);

    // 16-bit data, 4-bit address, no auto-increment
    sel = 1'b1;
    chk_en = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int b = 3; b >= 0; b--) drive(1'b0, (b < 2), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("d2_addr", {28'd0, dut2.addr_q}, 32'h3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(16'h1111, 16); push(16'h2222, 16); push(16'hBEEF, 16);
    for (int j = 0; j < 48; j++) drive(1'b0, pl[j], 1'b0, 1'b0, 1'b0);
    pl.delete();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("d2_addr_hold", {28'd0, dut2.addr_q}, 32'h3);
    check("d2_mem3", {16'd0, dut2.mem[4'h3]}, 32'hBEEF);
    check("d2_err", {31'd0, frame_err2}, 32'd0);
    check("d2_busy", {31'd0, busy2}, 32'd0);
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
